// File: rtl/systolic_pkg.sv
// Shared definitions for the systolic matrix multiplier: default array
// dimension and float word width, the float zero encoding, and the state
// encoding of the operand skew feeder.
package systolic_pkg;

    localparam int unsigned N_DEF = 4;
    localparam int unsigned W_DEF = 8;

    localparam logic [W_DEF-1:0] FP_ZERO = 8'h00;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_STREAM = 2'd1,
        ST_DRAIN  = 2'd2,
        ST_DONE   = 2'd3
    } feeder_state_e;

    // Index width of an N-entry dimension, never below one bit.
    function automatic int unsigned idx_width(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/systolic_skew_feeder_buf.sv
// matrix_row_buf: NxN operand register file.
//   clk        in   clock
//   rst_n      in   synchronous active-low reset, clears every element to FP_ZERO
//   wr_en      in   write one full row
//   wr_row     in   row index to write
//   wr_data    in   row data, element c at [c*W +: W]
//   rd_row     in   per-lane row index (N lanes)
//   rd_col     in   per-lane column index (N lanes)
//   rd_data    out  per-lane element [rd_row][rd_col], combinational
module matrix_row_buf
    import systolic_pkg::*;
#(
    parameter int unsigned N  = N_DEF,
    parameter int unsigned W  = W_DEF,
    parameter int unsigned RW = idx_width(N)
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   wr_en,
    input  logic [RW-1:0]          wr_row,
    input  logic [N*W-1:0]         wr_data,
    input  logic [N-1:0][RW-1:0]   rd_row,
    input  logic [N-1:0][RW-1:0]   rd_col,
    output logic [N-1:0][W-1:0]    rd_data
);

    // mem_q[row][col]; a packed row lines up with the flat write data.
    logic [N-1:0][N-1:0][W-1:0] mem_q;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            mem_q <= '0;
        end else if (wr_en) begin
            mem_q[wr_row] <= wr_data;
        end
    end

    always_comb begin
        rd_data = '0;
        for (int unsigned l = 0; l < N; l++) begin
            rd_data[l] = mem_q[rd_row[l]][rd_col[l]];
        end
    end

endmodule

// File: rtl/systolic_skew_feeder.sv
// systolic_skew_feeder: buffers one NxN matrix A and one NxN matrix B, then
// streams them diagonally skewed into the PE array edges so that A[i][k] and
// B[k][j] meet in PE(i,j) on the same cycle, and pulses done after a drain.
//   clk, rst_n   clock, synchronous active-low reset
//   load_valid   load beat present; accepted when load_ready is high (IDLE)
//   load_ready   high only in IDLE
//   load_sel     0: row of A, 1: row of B
//   load_row     row index
//   load_data    row data, element k at [k*W +: W]
//   start        begin streaming (honoured in IDLE only)
//   busy         high while streaming and draining
//   done         one-cycle pulse at the end of the drain
//   a_out/a_vld  row-edge operands and per-lane real-data flags
//   b_out/b_vld  column-edge operands and per-lane real-data flags
module systolic_skew_feeder
    import systolic_pkg::*;
#(
    parameter int unsigned N     = N_DEF,
    parameter int unsigned W     = W_DEF,
    parameter int unsigned DRAIN = 8
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     load_valid,
    output logic                     load_ready,
    input  logic                     load_sel,
    input  logic [idx_width(N)-1:0]  load_row,
    input  logic [N*W-1:0]           load_data,
    input  logic                     start,
    output logic                     busy,
    output logic                     done,
    output logic [N*W-1:0]           a_out,
    output logic [N*W-1:0]           b_out,
    output logic [N-1:0]             a_vld,
    output logic [N-1:0]             b_vld
);

    localparam int unsigned RW = idx_width(N);
    localparam int unsigned TW = $clog2(2*N-1);
    localparam int unsigned DW = (DRAIN > 0) ? $clog2(DRAIN+1) : 1;
    localparam logic [TW-1:0] T_LAST = TW'(2*N-2);
    localparam logic [DW-1:0] D_LAST = DW'((DRAIN > 0) ? DRAIN-1 : 0);

    feeder_state_e state_q, state_d;
    logic [TW-1:0] t_q, t_d;
    logic [DW-1:0] d_q, d_d;

    logic [N-1:0][W-1:0] a_out_q, a_out_d, b_out_q, b_out_d;
    logic [N-1:0]        a_vld_q, a_vld_d, b_vld_q, b_vld_d;
    logic                busy_q, busy_d, done_q, done_d;

    logic [N-1:0][RW-1:0] a_row, a_col, b_row, b_col;
    logic [N-1:0][W-1:0]  a_rd, b_rd;
    logic [N-1:0]         a_ok, b_ok;
    logic                 wr_a, wr_b;

    assign load_ready = (state_q == ST_IDLE);
    assign wr_a       = load_valid && load_ready && !load_sel;
    assign wr_b       = load_valid && load_ready &&  load_sel;

    matrix_row_buf #(.N(N), .W(W), .RW(RW)) u_buf_a (
        .clk     (clk),
        .rst_n   (rst_n),
        .wr_en   (wr_a),
        .wr_row  (load_row),
        .wr_data (load_data),
        .rd_row  (a_row),
        .rd_col  (a_col),
        .rd_data (a_rd)
    );

    matrix_row_buf #(.N(N), .W(W), .RW(RW)) u_buf_b (
        .clk     (clk),
        .rst_n   (rst_n),
        .wr_en   (wr_b),
        .wr_row  (load_row),
        .wr_data (load_data),
        .rd_row  (b_row),
        .rd_col  (b_col),
        .rd_data (b_rd)
    );

    // Skew: lane l carries the element whose inner index is t-l, valid only
    // while 0 <= t-l < N. A lane l reads A[l][t-l]; B lane l reads B[t-l][l].
    always_comb begin
        a_row = '0;
        a_col = '0;
        b_row = '0;
        b_col = '0;
        a_ok  = '0;
        b_ok  = '0;
        for (int unsigned l = 0; l < N; l++) begin
            if ((t_q >= TW'(l)) && ((t_q - TW'(l)) < TW'(N))) begin
                a_ok[l]  = 1'b1;
                b_ok[l]  = 1'b1;
                a_row[l] = RW'(l);
                a_col[l] = RW'(t_q - TW'(l));
                b_row[l] = RW'(t_q - TW'(l));
                b_col[l] = RW'(l);
            end
        end
    end

    always_comb begin
        state_d = state_q;
        t_d     = t_q;
        d_d     = d_q;
        unique case (state_q)
            ST_IDLE: begin
                if (start) begin
                    state_d = ST_STREAM;
                    t_d     = '0;
                end
            end
            ST_STREAM: begin
                if (t_q == T_LAST) begin
                    t_d     = '0;
                    d_d     = '0;
                    state_d = (DRAIN == 0) ? ST_DONE : ST_DRAIN;
                end else begin
                    t_d = t_q + 1'b1;
                end
            end
            ST_DRAIN: begin
                if (d_q == D_LAST) begin
                    d_d     = '0;
                    state_d = ST_DONE;
                end else begin
                    d_d = d_q + 1'b1;
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // Output registers follow the state one edge later, so a beat computed
    // while in STREAM with counter t becomes visible after the next edge.
    always_comb begin
        a_out_d = '0;
        b_out_d = '0;
        a_vld_d = '0;
        b_vld_d = '0;
        busy_d  = (state_q == ST_STREAM) || (state_q == ST_DRAIN);
        done_d  = (state_q == ST_DONE);
        if (state_q == ST_STREAM) begin
            for (int unsigned l = 0; l < N; l++) begin
                a_vld_d[l] = a_ok[l];
                b_vld_d[l] = b_ok[l];
                a_out_d[l] = a_ok[l] ? a_rd[l] : W'(FP_ZERO);
                b_out_d[l] = b_ok[l] ? b_rd[l] : W'(FP_ZERO);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            t_q     <= '0;
            d_q     <= '0;
            a_out_q <= '0;
            b_out_q <= '0;
            a_vld_q <= '0;
            b_vld_q <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            t_q     <= t_d;
            d_q     <= d_d;
            a_out_q <= a_out_d;
            b_out_q <= b_out_d;
            a_vld_q <= a_vld_d;
            b_vld_q <= b_vld_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

    assign a_out = a_out_q;
    assign b_out = b_out_q;
    assign a_vld = a_vld_q;
    assign b_vld = b_vld_q;
    assign busy  = busy_q;
    assign done  = done_q;

endmodule

// File: tb/tb_systolic_skew_feeder.sv
module tb_systolic_skew_feeder;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    // Main instance: N=4, DRAIN=8
    logic        rst_n, load_valid, load_ready, load_sel, start, busy, done;
    logic [1:0]  load_row;
    logic [31:0] load_data, a_out, b_out;
    logic [3:0]  a_vld, b_vld;

    // Small instance: N=2, DRAIN=0
    logic        load_ready1, start1, busy1, done1;
    logic [15:0] a_out1, b_out1;
    logic [1:0]  a_vld1, b_vld1;

    systolic_skew_feeder #(.N(4), .W(8), .DRAIN(8)) dut (
        .clk(clk), .rst_n(rst_n), .load_valid(load_valid), .load_ready(load_ready),
        .load_sel(load_sel), .load_row(load_row), .load_data(load_data), .start(start),
        .busy(busy), .done(done), .a_out(a_out), .b_out(b_out), .a_vld(a_vld), .b_vld(b_vld)
    );

    systolic_skew_feeder #(.N(2), .W(8), .DRAIN(0)) dut1 (
        .clk(clk), .rst_n(rst_n), .load_valid(1'b0), .load_ready(load_ready1),
        .load_sel(1'b0), .load_row(1'b0), .load_data(16'h0000), .start(start1),
        .busy(busy1), .done(done1), .a_out(a_out1), .b_out(b_out1), .a_vld(a_vld1), .b_vld(b_vld1)
    );

    int n_checks = 0;
    int n_errors = 0;

    // Reference matrices as the bench believes the buffers hold them.
    logic [7:0] mA [4][4];
    logic [7:0] mB [4][4];

    logic [31:0] obs_a [7];
    logic [31:0] obs_b [7];
    logic [3:0]  obs_av[7];
    logic [3:0]  obs_bv[7];

    typedef struct {
        int          t;
        logic [31:0] a;
        logic [3:0]  av;
        logic [31:0] b;
        logic [3:0]  bv;
    } beat_vec_t;

    beat_vec_t tab[4];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic void model_clear();
        for (int r = 0; r < 4; r++)
            for (int c = 0; c < 4; c++) begin
                mA[r][c] = 8'h00;
                mB[r][c] = 8'h00;
            end
    endfunction

    function automatic void model_write(input bit sel, input int row, input logic [31:0] data);
        for (int c = 0; c < 4; c++) begin
            if (sel) mB[row][c] = data[c*8 +: 8];
            else     mA[row][c] = data[c*8 +: 8];
        end
    endfunction

    // Beat t: A[i][k] enters row i at cycle t=i+k; B[k][j] enters column j at t=k+j.
    function automatic logic [31:0] exp_a(input int t);
        logic [31:0] r = '0;
        for (int i = 0; i < 4; i++)
            if (t - i >= 0 && t - i < 4) r[i*8 +: 8] = mA[i][t-i];
        return r;
    endfunction

    function automatic logic [31:0] exp_b(input int t);
        logic [31:0] r = '0;
        for (int j = 0; j < 4; j++)
            if (t - j >= 0 && t - j < 4) r[j*8 +: 8] = mB[t-j][j];
        return r;
    endfunction

    function automatic logic [3:0] exp_v(input int t);
        logic [3:0] r = '0;
        for (int i = 0; i < 4; i++)
            if (t - i >= 0 && t - i < 4) r[i] = 1'b1;
        return r;
    endfunction

    task automatic do_load(input bit sel, input int row, input logic [31:0] data);
        load_valid = 1'b1;
        load_sel   = sel;
        load_row   = row[1:0];
        load_data  = data;
        chk("load_ready_idle", {63'd0, load_ready}, 64'd1);
        tick();
        load_valid = 1'b0;
        model_write(sel, row, data);
    endtask

    // One full run from IDLE: start edge k, beats after k+1..k+7, drain
    // after k+8..k+15, done after k+16.
    task automatic run_check(input bit with_load, input bit sel, input int row,
                             input logic [31:0] data, input bit stray);
        int t;
        start = 1'b1;
        if (with_load) begin
            load_valid = 1'b1;
            load_sel   = sel;
            load_row   = row[1:0];
            load_data  = data;
        end
        tick();
        start      = 1'b0;
        load_valid = 1'b0;
        if (with_load) model_write(sel, row, data);
        if (stray) begin
            load_valid = 1'b1;
            load_sel   = 1'($urandom_range(0, 1));
            load_row   = 2'($urandom_range(0, 3));
            load_data  = $urandom;
        end
        for (int c = 1; c <= 16; c++) begin
            tick();
            if (c <= 7) begin
                t = c - 1;
                obs_a[t]  = a_out;
                obs_b[t]  = b_out;
                obs_av[t] = a_vld;
                obs_bv[t] = b_vld;
                chk($sformatf("a_out t=%0d", t), {32'd0, a_out}, {32'd0, exp_a(t)});
                chk($sformatf("b_out t=%0d", t), {32'd0, b_out}, {32'd0, exp_b(t)});
                chk($sformatf("vld t=%0d", t), {56'd0, a_vld, b_vld}, {56'd0, exp_v(t), exp_v(t)});
            end else begin
                chk($sformatf("idle_out c=%0d", c), {a_out, b_out}, 64'd0);
                chk($sformatf("idle_vld c=%0d", c), {56'd0, a_vld, b_vld}, 64'd0);
            end
            chk($sformatf("busy c=%0d", c), {63'd0, busy}, {63'd0, (c <= 15)});
            chk($sformatf("done c=%0d", c), {63'd0, done}, {63'd0, (c == 16)});
            chk($sformatf("load_ready c=%0d", c), {63'd0, load_ready}, {63'd0, (c == 16)});
            if (c == 15) load_valid = 1'b0;
        end
        tick();
        chk("done_one_cycle", {63'd0, done}, 64'd0);
    endtask

    initial begin
        logic [31:0] d;
        int          ndone;
        int          m;

        // Hand-derived beats for A[i][k]=10h+4i+k and B with 8'h38 on the diagonal.
        tab[0] = '{t: 0, a: 32'h0000_0010, av: 4'b0001, b: 32'h0000_0038, bv: 4'b0001};
        tab[1] = '{t: 3, a: 32'h1C19_1613, av: 4'b1111, b: 32'h0000_0000, bv: 4'b1111};
        tab[2] = '{t: 4, a: 32'h1D1A_1700, av: 4'b1110, b: 32'h0038_0000, bv: 4'b1110};
        tab[3] = '{t: 6, a: 32'h1F00_0000, av: 4'b1000, b: 32'h3800_0000, bv: 4'b1000};

        // Reset with a load beat asserted: nothing may be written.
        rst_n      = 1'b0;
        load_valid = 1'b1;
        load_sel   = 1'b0;
        load_row   = 2'd0;
        load_data  = 32'hFFFF_FFFF;
        start      = 1'b0;
        start1     = 1'b0;
        repeat (3) tick();
        rst_n      = 1'b1;
        load_valid = 1'b0;
        model_clear();
        chk("rst load_ready", {63'd0, load_ready}, 64'd1);
        chk("rst busy_done", {62'd0, busy, done}, 64'd0);
        chk("rst outputs", {a_out, b_out}, 64'd0);
        chk("rst vld", {56'd0, a_vld, b_vld}, 64'd0);
        chk("rst dut1", {61'd0, load_ready1, busy1, done1}, 64'd4);
        tick();
        // Buffers must read back zero.
        run_check(1'b0, 1'b0, 0, 32'd0, 1'b0);

        // Directed pattern, with stray load beats during the run.
        for (int i = 0; i < 4; i++) begin
            for (int k = 0; k < 4; k++) d[k*8 +: 8] = 8'(8'h10 + 4*i + k);
            do_load(1'b0, i, d);
        end
        for (int r = 0; r < 4; r++) begin
            d = '0;
            d[r*8 +: 8] = 8'h38;
            do_load(1'b1, r, d);
        end
        run_check(1'b0, 1'b0, 0, 32'd0, 1'b1);
        for (int v = 0; v < 4; v++) begin
            chk($sformatf("tab a t=%0d", tab[v].t), {32'd0, obs_a[tab[v].t]}, {32'd0, tab[v].a});
            chk($sformatf("tab b t=%0d", tab[v].t), {32'd0, obs_b[tab[v].t]}, {32'd0, tab[v].b});
            chk($sformatf("tab vld t=%0d", tab[v].t), {56'd0, obs_av[tab[v].t], obs_bv[tab[v].t]},
                {56'd0, tab[v].av, tab[v].bv});
        end
        // Buffers untouched by the stray beats.
        run_check(1'b0, 1'b0, 0, 32'd0, 1'b0);

        // Load and start in the same cycle.
        run_check(1'b1, 1'b0, 0, 32'hAAAA_AAAA, 1'b0);
        d = obs_a[0];
        chk("same_cycle lane0", {56'd0, d[7:0]}, 64'hAA);

        // Reset during beat t=3.
        start = 1'b1;
        tick();
        start = 1'b0;
        repeat (4) tick();
        chk("pre-abort vld", {60'd0, a_vld}, 64'hF);
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        model_clear();
        chk("abort outputs", {a_out, b_out}, 64'd0);
        chk("abort vld", {56'd0, a_vld, b_vld}, 64'd0);
        chk("abort busy_done", {62'd0, busy, done}, 64'd0);
        chk("abort load_ready", {63'd0, load_ready}, 64'd1);
        for (int c = 0; c < 5; c++) begin
            tick();
            chk($sformatf("abort no_done c=%0d", c), {62'd0, busy, done}, 64'd0);
        end
        // Cleared buffers stream zeros with the skewed valid flags.
        run_check(1'b0, 1'b0, 0, 32'd0, 1'b0);

        // Randomised loads and runs.
        for (int r = 0; r < 4; r++) begin
            for (int b = 0; b < 6; b++)
                do_load(1'($urandom_range(0, 1)), int'($urandom_range(0, 3)), $urandom);
            run_check(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                      int'($urandom_range(0, 3)), $urandom, 1'b1);
        end

        // N=2, DRAIN=0 with start held: one run every 5 edges.
        ndone  = 0;
        start1 = 1'b1;
        for (int c = 0; c < 20; c++) begin
            tick();
            m = c % 5;
            if (done1) ndone++;
            chk($sformatf("n2 busy c=%0d", c), {63'd0, busy1}, {63'd0, (m >= 1 && m <= 3)});
            chk($sformatf("n2 done c=%0d", c), {63'd0, done1}, {63'd0, (m == 4)});
            if (m >= 1 && m <= 3)
                chk($sformatf("n2 a_vld c=%0d", c), {62'd0, a_vld1},
                    {62'd0, (m >= 2), (m <= 2)});
        end
        start1 = 1'b0;
        chk("n2 done count", 64'(ndone), 64'd4);
        chk("n2 outputs zero", {32'd0, a_out1, b_out1}, 64'd0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
